// File: rtl/fht_pkg.sv
// Shared constants, FSM states and index helper for the FHT host-side stream block.
package fht_pkg;

    localparam int unsigned N_BANK    = 4;
    localparam int unsigned A_BIT_DEF = 8;
    localparam int unsigned N_PTS     = N_BANK << A_BIT_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_LO,
        RUN,
        UNLOAD
    } fht_state_e;

    // Reverse the low w bits of x; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) r[5'(w - 1 - i)] = x[5'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_skid_fifo.sv
// Two-entry output FIFO; head and occupancy are registers so oDATA/oVALID come straight from flops.
module fht_skid_fifo
#(
    parameter int unsigned D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iPUSH,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iPOP,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    output logic [1:0]       oCOUNT
);

    logic [D_BIT-1:0] tail;
    logic [D_BIT-1:0] head_nxt;
    logic [D_BIT-1:0] tail_nxt;
    logic [1:0]       cnt_nxt;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        head_nxt = oDATA;
        tail_nxt = tail;
        cnt_nxt  = oCOUNT;
        pop_ok   = iPOP && (oCOUNT != 2'd0);
        push_ok  = iPUSH && ((oCOUNT != 2'd2) || pop_ok);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (oCOUNT == 2'd0) head_nxt = iDATA;
                else                tail_nxt = iDATA;
                cnt_nxt = oCOUNT + 2'd1;
            end
            2'b01: begin
                head_nxt = tail;
                cnt_nxt  = oCOUNT - 2'd1;
            end
            // Simultaneous push and pop keeps the occupancy unchanged.
            2'b11: begin
                if (oCOUNT == 2'd1) begin
                    head_nxt = iDATA;
                end else begin
                    head_nxt = tail;
                    tail_nxt = iDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oDATA  <= '0;
            tail   <= '0;
            oCOUNT <= 2'd0;
            oVALID <= 1'b0;
        end else begin
            oDATA  <= head_nxt;
            tail   <= tail_nxt;
            oCOUNT <= cnt_nxt;
            oVALID <= (cnt_nxt != 2'd0);
        end
    end

endmodule

// File: rtl/fht_stream_io.sv
// Host stream front/back end of the FHT core: loads bank set A, kicks the core, streams results out.
// Define FHT_BITREV_LOAD_EN to bit-reverse the load index in hardware; otherwise samples land in arrival order.
module fht_stream_io
    import fht_pkg::*;
#(
    parameter int unsigned A_BIT = A_BIT_DEF,
    parameter int unsigned D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic             oBANK_OWN,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_RD_0,
    input  logic [D_BIT-1:0] iDATA_RD_1,
    input  logic [D_BIT-1:0] iDATA_RD_2,
    input  logic [D_BIT-1:0] iDATA_RD_3,
    output logic             oBUSY
);

    localparam int unsigned     C_BIT    = A_BIT + 2;
    localparam int unsigned     N_TOT    = N_BANK << A_BIT;
    localparam logic [C_BIT-1:0] LAST_IDX = C_BIT'(N_TOT - 1);

    fht_state_e       state;
    fht_state_e       state_nxt;
    logic [C_BIT-1:0] load_idx,  load_idx_nxt;
    logic [C_BIT-1:0] issue_idx, issue_idx_nxt;
    logic [C_BIT-1:0] pop_idx,   pop_idx_nxt;
    logic             issue_done, issue_done_nxt;
    logic             rd_vld, rd_vld_nxt;
    logic [1:0]       rd_bank, rd_bank_nxt;

    logic             ready_nxt, start_nxt, own_nxt, busy_nxt;
    logic [A_BIT-1:0] addr_wr_nxt, addr_rd_nxt;
    logic [D_BIT-1:0] data_wr_nxt;
    logic [3:0]       we_nxt;

    logic [C_BIT-1:0] slot_c;
    logic             accept_c, pop_c, issue_c;
    logic [D_BIT-1:0] rd_data_c;
    logic [1:0]       fifo_cnt;

`ifdef FHT_BITREV_LOAD_EN
    assign slot_c = C_BIT'(bitrev(32'(load_idx), C_BIT));
`else
    assign slot_c = load_idx;
`endif

    assign accept_c = iVALID && oREADY;
    assign pop_c    = oVALID && iREADY;
    // Occupancy is taken after this cycle's pop so a steady iREADY=1 stream never bubbles.
    assign issue_c  = (state == UNLOAD) && !issue_done &&
                      ((3'(fifo_cnt) - 3'(pop_c) + 3'(rd_vld)) < 3'd2);

    always_comb begin
        case (rd_bank)
            2'd0:    rd_data_c = iDATA_RD_0;
            2'd1:    rd_data_c = iDATA_RD_1;
            2'd2:    rd_data_c = iDATA_RD_2;
            default: rd_data_c = iDATA_RD_3;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        load_idx_nxt   = load_idx;
        issue_idx_nxt  = issue_idx;
        pop_idx_nxt    = pop_idx;
        issue_done_nxt = issue_done;
        rd_vld_nxt     = issue_c;
        rd_bank_nxt    = rd_bank;
        we_nxt         = 4'b0000;
        addr_wr_nxt    = oADDR_WR;
        data_wr_nxt    = oDATA_WR;

        case (state)
            IDLE: begin
                if (iFHT_RDY) state_nxt = LOAD;
            end
            LOAD: begin
                if (accept_c) begin
                    we_nxt       = 4'b0001 << slot_c[1:0];
                    addr_wr_nxt  = slot_c[C_BIT-1:2];
                    data_wr_nxt  = iDATA;
                    load_idx_nxt = load_idx + C_BIT'(1);
                    if (load_idx == LAST_IDX) state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!iFHT_RDY) state_nxt = RUN;
            end
            RUN: begin
                if (iFHT_RDY) begin
                    state_nxt      = UNLOAD;
                    issue_done_nxt = 1'b0;
                end
            end
            UNLOAD: begin
                if (issue_c) begin
                    rd_bank_nxt   = issue_idx[1:0];
                    issue_idx_nxt = issue_idx + C_BIT'(1);
                    if (issue_idx == LAST_IDX) issue_done_nxt = 1'b1;
                end
                if (pop_c) begin
                    pop_idx_nxt = pop_idx + C_BIT'(1);
                    if (pop_idx == LAST_IDX) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The read address leads the issue so the RAM already holds it when the read is issued.
        addr_rd_nxt = issue_idx_nxt[C_BIT-1:2];
        ready_nxt   = (state_nxt == LOAD);
        start_nxt   = (state_nxt == START);
        own_nxt     = (state_nxt == LOAD) || (state_nxt == UNLOAD);
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state      <= IDLE;
            load_idx   <= '0;
            issue_idx  <= '0;
            pop_idx    <= '0;
            issue_done <= 1'b0;
            rd_vld     <= 1'b0;
            rd_bank    <= 2'd0;
            oREADY     <= 1'b0;
            oFHT_START <= 1'b0;
            oBANK_OWN  <= 1'b0;
            oBUSY      <= 1'b0;
            oADDR_WR   <= '0;
            oDATA_WR   <= '0;
            oWE        <= 4'b0000;
            oADDR_RD   <= '0;
        end else begin
            state      <= state_nxt;
            load_idx   <= load_idx_nxt;
            issue_idx  <= issue_idx_nxt;
            pop_idx    <= pop_idx_nxt;
            issue_done <= issue_done_nxt;
            rd_vld     <= rd_vld_nxt;
            rd_bank    <= rd_bank_nxt;
            oREADY     <= ready_nxt;
            oFHT_START <= start_nxt;
            oBANK_OWN  <= own_nxt;
            oBUSY      <= busy_nxt;
            oADDR_WR   <= addr_wr_nxt;
            oDATA_WR   <= data_wr_nxt;
            oWE        <= we_nxt;
            oADDR_RD   <= addr_rd_nxt;
        end
    end

    fht_skid_fifo #(
        .D_BIT (D_BIT)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iPUSH  (rd_vld),
        .iDATA  (rd_data_c),
        .iPOP   (pop_c),
        .oDATA  (oDATA),
        .oVALID (oVALID),
        .oCOUNT (fifo_cnt)
    );

endmodule

// File: tb/tb_fht_stream_io.sv
// Scoreboard bench for fht_stream_io: bank RAM and core model, write and result queues checked by a monitor.
module tb_fht_stream_io;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N     = 1024;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID;
    logic             iREADY;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic             oBANK_OWN;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA_WR;
    logic [3:0]       oWE;
    logic [A_BIT-1:0] oADDR_RD;
    logic [D_BIT-1:0] rd_q [4];
    logic             oBUSY;

    logic [D_BIT-1:0] mem [4][256];
    logic [27:0]      wq [$];
    logic [D_BIT-1:0] rq [$];
    logic             core_fill;
    logic             sb_en;
    int               run_id;
    int               errors = 0;
    int               checks = 0;
    int               wcnt   = 0;
    int               pop_cnt = 0;

    always #5 iCLK = ~iCLK;

    fht_stream_io dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iDATA      (iDATA),
        .iVALID     (iVALID),
        .oREADY     (oREADY),
        .oDATA      (oDATA),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oFHT_START (oFHT_START),
        .iFHT_RDY   (iFHT_RDY),
        .oBANK_OWN  (oBANK_OWN),
        .oADDR_WR   (oADDR_WR),
        .oDATA_WR   (oDATA_WR),
        .oWE        (oWE),
        .oADDR_RD   (oADDR_RD),
        .iDATA_RD_0 (rd_q[0]),
        .iDATA_RD_1 (rd_q[1]),
        .iDATA_RD_2 (rd_q[2]),
        .iDATA_RD_3 (rd_q[3]),
        .oBUSY      (oBUSY)
    );

    function automatic logic [D_BIT-1:0] res_f(input int n, input int r);
        int v;
        v = n * 911 + r * 4099 + 123;
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    // Registered bank RAM (1-cycle read) plus the core writing its results into it.
    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (oWE[b] && oBANK_OWN) mem[b][oADDR_WR] <= oDATA_WR;
            rd_q[b] <= mem[b][oADDR_RD];
        end
        if (core_fill) begin
            for (int n = 0; n < N; n++) mem[n % 4][n / 4] <= res_f(n, run_id);
        end
    end

    // Monitor: bank writes against the write queue, results against the result queue.
    always @(negedge iCLK) begin
        logic [27:0] exp_w;
        if (!iRESET && sb_en) begin
            if (oWE != 4'b0000) begin
                if (wq.size() == 0) begin
                    fail("stray_bank_write");
                end else begin
                    exp_w = wq.pop_front();
                    chk("bank_write", 64'({oWE, oADDR_WR, oDATA_WR}), 64'(exp_w));
`ifdef FHT_BITREV_LOAD_EN
                    if (wcnt == 1)   chk("k1_slot",   64'({oWE, oADDR_WR}), 64'({4'b0001, 8'd128}));
                    if (wcnt == 256) chk("k256_slot", 64'({oWE, oADDR_WR}), 64'({4'b0100, 8'd0}));
                    if (wcnt == 3)   chk("k3_slot",   64'({oWE, oADDR_WR}), 64'({4'b0001, 8'd192}));
`else
                    if (wcnt == 5)    chk("k5_slot",    64'({oWE, oADDR_WR}), 64'({4'b0010, 8'd1}));
                    if (wcnt == 1023) chk("k1023_slot", 64'({oWE, oADDR_WR}), 64'({4'b1000, 8'd255}));
`endif
                    wcnt++;
                end
            end
            if (oVALID) begin
                chk("fifo_count_le2", 64'(dut.u_fifo.oCOUNT <= 2'd2), 64'd1);
                if (rq.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    chk("result_data", 64'(oDATA), 64'(rq[0]));
                    if (iREADY) begin
                        void'(rq.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_load(input int run);
        logic       r;
        int         guard;
        logic [9:0] kk;
        logic [9:0] slot;
        for (int k = 0; k < N; k++) begin
            iDATA    = (run == 0) ? 16'(k) : ~16'(k);
            iVALID   = 1'b1;
            iFHT_RDY = !(run == 1 && k == 100);
            guard    = 0;
            do begin
                @(negedge iCLK);
                r = oREADY;
                @(posedge iCLK);
                #1;
                guard++;
            end while (!r && guard < 50);
            if (!r) begin
                fail("load_ready_timeout");
                return;
            end
            kk = 10'(k);
`ifdef FHT_BITREV_LOAD_EN
            slot = {<<{kk}};
`else
            slot = kk;
`endif
            wq.push_back({4'b0001 << slot[1:0], slot[9:2], iDATA});
        end
        iFHT_RDY = 1'b1;
    endtask

    task automatic run_core(input int run);
        int starts;
        int own_bad;
        chk("ready_low_after_load", 64'(oREADY), 64'd0);
        if (!oFHT_START) begin
            fail("start_pulse_missing");
            starts = 0;
        end else begin
            starts = 1;
        end
        own_bad = oBANK_OWN ? 1 : 0;
        @(posedge iCLK);
        #1 iFHT_RDY = 1'b0;
        for (int c = 0; c < 2600; c++) begin
            @(negedge iCLK);
            if (oFHT_START) starts++;
            if (oBANK_OWN) own_bad++;
            if (c == 4) iVALID = 1'b0;
        end
        core_fill = 1'b1;
        @(posedge iCLK);
        #1 core_fill = 1'b0;
        for (int n = 0; n < N; n++) rq.push_back(res_f(n, run));
        iFHT_RDY = 1'b1;
        chk("one_start_pulse", 64'(starts), 64'd1);
        chk("own_low_in_run", 64'(own_bad), 64'd0);
    endtask

    task automatic do_unload(input bit rnd);
        int cyc;
        int gaps;
        int fv;
        int p0;
        p0  = pop_cnt;
        cyc = 0;
        gaps = 0;
        fv  = 0;
        while (cyc < 20000) begin
            @(posedge iCLK);
            #1;
            cyc++;
            iREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) iFHT_RDY = (cyc != 10);
            if (!oBUSY) break;
            if (oVALID) begin
                if (fv == 0) fv = cyc;
            end else if (fv != 0) begin
                gaps++;
            end
        end
        if (oBUSY) fail("unload_timeout");
        chk("unload_pop_count", 64'(pop_cnt - p0), 64'(N));
        chk("unload_queue_empty", 64'(rq.size()), 64'd0);
        chk("idle_valid_low", 64'(oVALID), 64'd0);
        if (!rnd) begin
            chk("unload_no_gaps", 64'(gaps), 64'd0);
            chk("unload_first_valid_soon", 64'(fv > 0 && fv <= 3), 64'd1);
        end
        iREADY = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET    = 1'b1;
        iVALID    = 1'b0;
        iDATA     = '0;
        iREADY    = 1'b0;
        iFHT_RDY  = 1'b1;
        core_fill = 1'b0;
        sb_en     = 1'b0;
        run_id    = 0;

        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_outputs", 64'({oREADY, oVALID, oFHT_START, oBANK_OWN, oBUSY, oWE,
                                  oADDR_WR, oDATA_WR, oADDR_RD, oDATA}), 64'd0);
        iRESET = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("ready_after_reset", 64'(oREADY), 64'd1);

        iVALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            iDATA = 16'(k + 77);
            @(posedge iCLK);
            #1;
        end
        chk("busy_mid_load", 64'(oBUSY), 64'd1);
        iVALID = 1'b0;
        iRESET = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_mid_load", 64'({oREADY, oVALID, oFHT_START, oBANK_OWN, oBUSY, oWE,
                                   oADDR_WR, oDATA_WR, oADDR_RD, oDATA}), 64'd0);
        iRESET = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("ready_after_reset_release", 64'(oREADY), 64'd1);
        chk("own_in_load", 64'(oBANK_OWN), 64'd1);
        sb_en = 1'b1;

        run_id = 0;
        do_load(0);
        chk("writes_run0", 64'(wcnt + wq.size()), 64'(N));
        run_core(0);
        do_unload(1'b0);

        run_id = 1;
        do_load(1);
        run_core(1);
        do_unload(1'b1);

        repeat (2) @(posedge iCLK);
        #1;
        chk("total_writes", 64'(wcnt), 64'(2 * N));
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
        chk("total_pops", 64'(pop_cnt), 64'(2 * N));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
